data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 15, data-RAM word address width.
- DATA_W, 16, data word width.
- BURST_MAX, 4, maximum accepted transfers per locked ownership before forced release; legal range 1..16.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- mX_req, in, 1, master X (X=0 CPU, X=1 screen/IO scanner) requests a transfer this cycle.
- mX_we, in, 1, 1 = write, 0 = read.
- mX_lock, in, 1, master X asks to keep ownership after this transfer.
- mX_addr, in, ADDR_W, word address.
- mX_wdata, in, DATA_W, write data.
- mX_gnt, out, 1, master X owns the RAM this cycle.
- mX_rvalid, out, 1, read data for master X is valid this cycle.
- mX_rdata, out, DATA_W, read data.
- ram_addr, out, ADDR_W, RAM address.
- ram_we, out, 1, RAM write enable.
- ram_wdata, out, DATA_W, RAM write data.
- ram_rdata, in, DATA_W, RAM read data, valid one cycle after its address.

Function
REQ-003 FSM states SHALL be IDLE, OWN0 and OWN1, registered; mX_gnt SHALL be 1 exactly in state OWNX.
REQ-004 A transfer SHALL be accepted in any cycle with mX_gnt=1 and mX_req=1; the RAM port SHALL carry the owner's addr/we/wdata combinationally, with ram_we = mX_req & mX_we.
REQ-005 In IDLE, or when the owner has no request, the RAM port SHALL drive ram_we=0 and ram_addr=0.
REQ-006 Grant latency SHALL be one cycle: a request in cycle n from IDLE yields mX_gnt in cycle n+1.
REQ-007 Arbitration (from IDLE, or on release):
- Only one master requesting: grant that master.
- Neither requesting: go to IDLE.
- Both requesting: grant the master not granted last (rr_last pointer).
REQ-008 The owner SHALL release at the end of the cycle in which any of these holds:
- mX_req=0;
- an accepted transfer with mX_lock=0;
- an accepted transfer that brings the burst count to BURST_MAX while the other master requests.
On release, REQ-007 arbitration applies in the same cycle, giving a direct OWN0 to OWN1 handover with no IDLE bubble.
REQ-009 The burst counter SHALL clear on entry to OWNX, increment per accepted transfer, and saturate at BURST_MAX.
REQ-010 rr_last SHALL update to X on every entry to OWNX.
REQ-011 mX_rvalid SHALL be registered: 1 in cycle n+1 if a read by X was accepted in cycle n, regardless of any ownership change.
REQ-012 mX_rdata SHALL equal ram_rdata whenever mX_rvalid=1, and 0 otherwise.
REQ-013 Requests SHALL never be dropped: a request that is not granted stays pending while mX_req is held.

Reset
REQ-014 While reset=0, outputs SHALL be: state IDLE, all mX_gnt=0, all mX_rvalid=0, all mX_rdata=0, burst count 0, rr_last=1 (so master 0 wins the first tie), ram_we=0, ram_addr=0.
REQ-015 Reset asserted mid-burst SHALL abort immediately; in-flight reads SHALL NOT produce rvalid.

Configuration
REQ-016 Macro ARB_CPU_PRIORITY_EN:
- Defined: ties SHALL always go to master 0; master 0 is never preempted by the burst limit; master 1 is released after BURST_MAX transfers whenever master 0 requests.
- Undefined: round-robin per REQ-007 to REQ-010.

Structure
REQ-017 Package hack_arb_pkg SHALL hold the state enum, the default BURST_MAX, and ADDR_W/DATA_W constants.
REQ-018 Combinational winner selection SHALL live in sub-module arb_pick (inputs: req0, req1, rr_last; output: winner).

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single read: m0 reads addr 5 (RAM holds 1234) from IDLE -> m0_gnt in cycle 1, m0_rvalid=1 with m0_rdata=1234 in cycle 2.
- Tie after reset: both masters request without lock -> m0 granted first, then alternating m1, m0, m1 on successive transfers.
- Burst limit: m1 locked burst of 10 writes while m0 requests -> m1 releases after 4 transfers, m0 granted the next cycle, no IDLE cycle.
- Handover: m0 read accepted in the cycle it releases to m1 -> m0_rvalid next cycle, m1_rvalid=0.
- Mid-burst reset: reset pulsed low during an m0 locked burst -> all outputs at reset values immediately, m0 wins the next tie.
- Macro build: with ARB_CPU_PRIORITY_EN, a locked m0 burst of 10 with m1 requesting -> m0 keeps ownership for all 10 transfers.

Source files
------------

// File: rtl/hack_arb_pkg.sv
// Shared types and default sizes for the two-master data-RAM arbiter.
package hack_arb_pkg;

  localparam int unsigned ARB_ADDR_W    = 15;
  localparam int unsigned ARB_DATA_W    = 16;
  localparam int unsigned ARB_BURST_MAX = 4;
  // Wide enough for any legal BURST_MAX (1..16).
  localparam int unsigned BURST_CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Two-way winner select; winner=1 means master 1. Tie goes to the master not granted last.
module arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic winner
);

  assign winner = req1 & (~req0 | ~rr_last);

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-RAM arbiter between CPU (m0) and screen/IO scanner (m1) with locked bursts.
// Build option ARB_CPU_PRIORITY_EN: CPU wins every tie and is never burst-limited.
module data_mem_arbiter
  import hack_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned DATA_W    = ARB_DATA_W,
  parameter int unsigned BURST_MAX = ARB_BURST_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(BURST_MAX);

  arb_state_e             state_q, state_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                   rr_last_q, rr_last_d;
  logic                   gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                   rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                   acc0, acc1, at_limit, release_own;
  logic                   winner, pick_rr, lim0_en;

`ifdef ARB_CPU_PRIORITY_EN
  assign pick_rr = 1'b1;
  assign lim0_en = 1'b0;
`else
  assign pick_rr = rr_last_q;
  assign lim0_en = 1'b1;
`endif

  arb_pick u_arb_pick (
    .req0    (m0_req),
    .req1    (m1_req),
    .rr_last (pick_rr),
    .winner  (winner)
  );

  // RAM port follows the owner only while it is requesting.
  always_comb begin : ram_port_mux
    acc0      = (state_q == ST_OWN0) & m0_req;
    acc1      = (state_q == ST_OWN1) & m1_req;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (acc0) begin
      ram_addr  = m0_addr;
      ram_we    = m0_we;
      ram_wdata = m0_wdata;
    end else if (acc1) begin
      ram_addr  = m1_addr;
      ram_we    = m1_we;
      ram_wdata = m1_wdata;
    end
  end

  // Release and re-arbitrate in the same cycle, so handover has no idle bubble.
  always_comb begin : next_state
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    cnt_inc     = (cnt_q >= BURST_LIM) ? BURST_LIM : cnt_q + BURST_CNT_W'(1);
    at_limit    = (cnt_inc == BURST_LIM);
    release_own = 1'b1;
    case (state_q)
      ST_OWN0: release_own = ~m0_req | ~m0_lock | (lim0_en & at_limit & m1_req);
      ST_OWN1: release_own = ~m1_req | ~m1_lock | (at_limit & m0_req);
      default: release_own = 1'b1;
    endcase
    if (acc0 | acc1) begin
      cnt_d = cnt_inc;
    end
    if (release_own) begin
      cnt_d = '0;
      if (m0_req | m1_req) begin
        state_d   = winner ? ST_OWN1 : ST_OWN0;
        rr_last_d = winner;
      end else begin
        state_d = ST_IDLE;
      end
    end
    gnt0_d    = (state_d == ST_OWN0);
    gnt1_d    = (state_d == ST_OWN1);
    rvalid0_d = acc0 & ~m0_we;
    rvalid1_d = acc1 & ~m1_we;
  end

  always_ff @(posedge clk or negedge reset) begin : state_regs
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rvalid0_q ? ram_rdata : '0;
  assign m1_rdata  = rvalid1_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: transaction-level model checked every cycle plus literal pins.
module tb_data_mem_arbiter;

`ifdef ARB_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req [2];
  logic        we [2];
  logic        lock [2];
  logic [14:0] addr [2];
  logic [15:0] wdata [2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata, ram_rdata;

  int errors = 0;
  int checks = 0;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [5:0] a);
    return (a == 6'd5) ? 16'd1234 : (16'hA000 | 16'(a));
  endfunction

  // Synchronous RAM, one-cycle read latency; contents loaded on the first edge.
  logic [15:0] mem [64];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i[5:0]);
      mem_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr[5:0]] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr[5:0]];
  end

  // Transaction-level model of ownership and memory contents.
  int          own;
  int          burst;
  int          rr;
  bit          erv [2];
  logic [15:0] erd [2];
  bit          acc_prev [2];
  logic [15:0] mmem [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; burst = 0; rr = 1;
    for (int x = 0; x < 2; x++) begin
      erv[x] = 1'b0; erd[x] = 16'h0; acc_prev[x] = 1'b0;
    end
  endtask

  task automatic model_update();
    int w;
    bit rel;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int x = 0; x < 2; x++) begin
      erv[x] = 1'b0; acc_prev[x] = 1'b0;
    end
    if (own >= 0 && req[own]) begin
      acc_prev[own] = 1'b1;
      if (we[own]) mmem[addr[own][5:0]] = wdata[own];
      else begin
        erv[own] = 1'b1;
        erd[own] = mmem[addr[own][5:0]];
      end
    end
    rel = 1'b0;
    if (own < 0) rel = 1'b1;
    else if (!req[own] || !lock[own]) rel = 1'b1;
    else begin
      burst = (burst + 1 > BM) ? BM : burst + 1;
      if (!(PRIO && own == 0) && burst == BM && req[1 - own]) rel = 1'b1;
    end
    if (rel) begin
      if (req[0] && req[1]) w = PRIO ? 0 : (rr == 1 ? 0 : 1);
      else if (req[0]) w = 0;
      else if (req[1]) w = 1;
      else w = -1;
      own = w;
      burst = 0;
      if (w >= 0) rr = w;
    end
  endtask

  task automatic chk_master(input int x, input logic g, input logic rv, input logic [15:0] rd);
    chk($sformatf("m%0d_gnt", x), 32'(g), 32'(own == x));
    chk($sformatf("m%0d_rvalid", x), 32'(rv), 32'(erv[x]));
    chk($sformatf("m%0d_rdata", x), 32'(rd), 32'(erv[x] ? erd[x] : 16'h0));
  endtask

  task automatic compare();
    logic        e_we;
    logic [14:0] e_addr;
    e_we = 1'b0;
    e_addr = 15'h0;
    chk_master(0, m0_gnt, m0_rvalid, m0_rdata);
    chk_master(1, m1_gnt, m1_rvalid, m1_rdata);
    if (own >= 0) begin
      if (req[own]) begin
        e_we = we[own];
        e_addr = addr[own];
      end
    end
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(wdata[own]));
  endtask

  // One clock cycle: check mid-cycle, advance model at the edge, return just after it.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input int x, input logic r, input logic w, input logic l,
                       input logic [14:0] a, input logic [15:0] d);
    req[x] = r; we[x] = w; lock[x] = l; addr[x] = a; wdata[x] = d;
  endtask

  task automatic idle_inputs();
    drive(0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_m0_gnt"}, 32'(m0_gnt), 32'd0);
    chk({tag, "_m1_gnt"}, 32'(m1_gnt), 32'd0);
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    chk({tag, "_m0_rdata"}, 32'(m0_rdata), 32'd0);
    chk({tag, "_m1_rdata"}, 32'(m1_rdata), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    model_reset();
    #1;
    reset_values(tag);
    tick();
    reset = 1'b1;
  endtask

  int n0, n1, g0cnt;

  initial begin
    for (int i = 0; i < 64; i++) mmem[i] = init_val(i[5:0]);
    idle_inputs();
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset_values("por");
    reset = 1'b1;
    tick();

    // Single read of address 5 from idle.
    drive(0, 1'b1, 1'b0, 1'b0, 15'd5, 16'h0);
    tick();
    chk("s1_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("s1_m1_gnt", 32'(m1_gnt), 32'd0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 15'd0, 16'h0);
    chk("s1_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("s1_m0_rdata", 32'(m0_rdata), 32'd1234);
    tick();
    tick();

    // Tie right after reset, unlocked reads from both masters.
    pulse_reset("rst2");
    drive(0, 1'b1, 1'b0, 1'b0, 15'd10, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 15'd20, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("s2_m0_gnt_%0d", k), 32'(m0_gnt), PRIO ? 32'd1 : 32'(k % 2));
      chk($sformatf("s2_m1_gnt_%0d", k), 32'(m1_gnt), PRIO ? 32'd0 : 32'(1 - (k % 2)));
    end
    idle_inputs();
    tick();
    tick();

    // m1 locked 10-write burst, m0 starts requesting reads one cycle later.
    n0 = 0; n1 = 0;
    for (int c = 0; c < 30; c++) begin
      drive(1, n1 < 10, 1'b1, 1'b1, 15'(32 + n1), 16'(16'hB000 + n1));
      drive(0, c >= 1 && n0 < 3, 1'b0, 1'b0, 15'(40 + n0), 16'h0);
      tick();
      if (acc_prev[0]) n0++;
      if (acc_prev[1]) n1++;
      if (c <= 3) chk($sformatf("s3_m1_hold_%0d", c), 32'(m1_gnt), 32'd1);
      if (c == 4) begin
        chk("s3_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("s3_m1_gnt", 32'(m1_gnt), 32'd0);
      end
    end
    chk("s3_m1_done", 32'(n1), 32'd10);
    idle_inputs();
    tick();

    // Handover: m0 read accepted in the cycle ownership moves on.
    drive(0, 1'b1, 1'b0, 1'b0, 15'd33, 16'h0);
    tick();
    drive(1, 1'b1, 1'b1, 1'b0, 15'd50, 16'hC0DE);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 15'd0, 16'h0);
    chk("s4_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("s4_m0_rdata", 32'(m0_rdata), 32'hB001);
    chk("s4_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("s4_m1_gnt", 32'(m1_gnt), PRIO ? 32'd0 : 32'd1);
    tick();
    tick();
    idle_inputs();
    tick();
    tick();

    // Reset in the middle of an m0 locked read burst.
    for (int c = 0; c < 4; c++) begin
      drive(0, 1'b1, 1'b0, 1'b1, 15'(c), 16'h0);
      tick();
    end
    chk("s5_rvalid_before", 32'(m0_rvalid), 32'd1);
    pulse_reset("s5");
    drive(0, 1'b1, 1'b0, 1'b0, 15'd2, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 15'd3, 16'h0);
    tick();
    chk("s5_tie_m0", 32'(m0_gnt), 32'd1);
    chk("s5_tie_m1", 32'(m1_gnt), 32'd0);
    idle_inputs();
    tick();
    tick();

    // m0 locked 10-read burst while m1 keeps requesting.
    n0 = 0; g0cnt = 0;
    for (int c = 0; c < 30; c++) begin
      drive(0, n0 < 10, 1'b0, 1'b1, 15'(n0), 16'h0);
      drive(1, c >= 1 && c < 20, 1'b0, 1'b0, 15'd60, 16'h0);
      tick();
      if (acc_prev[0]) n0++;
      if (c <= 9 && m0_gnt) g0cnt++;
      if (c == 4) chk("s6_m0_gnt_c5", 32'(m0_gnt), PRIO ? 32'd1 : 32'd0);
    end
    chk("s6_m0_cycles", 32'(g0cnt), PRIO ? 32'd10 : 32'd8);
    idle_inputs();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
